// File: rtl/icache_resp_dispatcher_if.sv
// Response-path bundle between the icache lookup/MSHR completion stage,
// the dispatcher, and the three requesters (fetch, snoop, prefetch).
interface icache_resp_dispatcher_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 256
);
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [1:0]            rsp_src;
  logic [ID_WIDTH-1:0]   rsp_id;
  logic                  rsp_hit;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  prefetch_flush;

  logic                  upstream_txrsp_vld;
  logic                  upstream_txrsp_rdy;
  logic [ID_WIDTH-1:0]   upstream_txrsp_id;
  logic                  upstream_txrsp_hit;
  logic [DATA_WIDTH-1:0] upstream_txrsp_data;

  logic                  downstream_txsnp_vld;
  logic                  downstream_txsnp_rdy;
  logic [ID_WIDTH-1:0]   downstream_txsnp_id;
  logic                  downstream_txsnp_hit;

  logic                  prefetch_rsp_vld;
  logic                  prefetch_rsp_rdy;
  logic [ID_WIDTH-1:0]   prefetch_rsp_id;
  logic                  prefetch_rsp_hit;

  logic                  illegal_src_err;

  // Environment side: drives responses and consumer readies.
  modport master (
    output rsp_vld, rsp_src, rsp_id, rsp_hit, rsp_data, prefetch_flush,
    output upstream_txrsp_rdy, downstream_txsnp_rdy, prefetch_rsp_rdy,
    input  rsp_rdy, illegal_src_err,
    input  upstream_txrsp_vld, upstream_txrsp_id, upstream_txrsp_hit, upstream_txrsp_data,
    input  downstream_txsnp_vld, downstream_txsnp_id, downstream_txsnp_hit,
    input  prefetch_rsp_vld, prefetch_rsp_id, prefetch_rsp_hit
  );

  // Dispatcher side.
  modport slave (
    input  rsp_vld, rsp_src, rsp_id, rsp_hit, rsp_data, prefetch_flush,
    input  upstream_txrsp_rdy, downstream_txsnp_rdy, prefetch_rsp_rdy,
    output rsp_rdy, illegal_src_err,
    output upstream_txrsp_vld, upstream_txrsp_id, upstream_txrsp_hit, upstream_txrsp_data,
    output downstream_txsnp_vld, downstream_txsnp_id, downstream_txsnp_hit,
    output prefetch_rsp_vld, prefetch_rsp_id, prefetch_rsp_hit
  );
endinterface

// File: rtl/icache_resp_dispatcher.sv
// Routes icache lookup responses back to their requester through one FIFO
// per destination, so a stalled consumer only blocks its own traffic.
module icache_resp_dispatcher #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4
) (
  input  logic clk,
  input  logic rst,
  icache_resp_dispatcher_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [PW-1:0] u_wr, u_rd, s_wr, s_rd, p_wr, p_rd;
  logic [CW-1:0] u_cnt, s_cnt, p_cnt;

  logic [ID_WIDTH-1:0]   u_id   [FIFO_DEPTH];
  logic                  u_hit  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] u_data [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   s_id   [FIFO_DEPTH];
  logic                  s_hit  [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   p_id   [FIFO_DEPTH];
  logic                  p_hit  [FIFO_DEPTH];

  logic rdy, acc;
  logic u_push, s_push, p_push, p_write;
  logic u_pop, s_pop, p_pop;
  logic u_vld, s_vld, p_vld;
  logic err_q;

  // Readiness looks only at the selected FIFO's occupancy, never at consumer readies.
  always_comb begin
    rdy = 1'b1;
    case (bus.rsp_src)
      2'd0:    rdy = (u_cnt < FULL);
      2'd1:    rdy = (s_cnt < FULL);
      2'd2:    rdy = (p_cnt < FULL);
      default: rdy = 1'b1;
    endcase
  end

  assign acc     = bus.rsp_vld & rdy;
  assign u_push  = acc & (bus.rsp_src == 2'd0);
  assign s_push  = acc & (bus.rsp_src == 2'd1);
  assign p_push  = acc & (bus.rsp_src == 2'd2);
  // A prefetch response arriving together with a flush is dropped with the rest.
  assign p_write = p_push & ~bus.prefetch_flush;

  assign u_vld = (u_cnt != '0);
  assign s_vld = (s_cnt != '0);
  assign p_vld = (p_cnt != '0);
  assign u_pop = u_vld & bus.upstream_txrsp_rdy;
  assign s_pop = s_vld & bus.downstream_txsnp_rdy;
  assign p_pop = p_vld & bus.prefetch_rsp_rdy;

  // Entry storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    if (u_push) begin
      u_id[u_wr]   <= bus.rsp_id;
      u_hit[u_wr]  <= bus.rsp_hit;
      u_data[u_wr] <= bus.rsp_data;
    end
    if (s_push) begin
      s_id[s_wr]  <= bus.rsp_id;
      s_hit[s_wr] <= bus.rsp_hit;
    end
    if (p_write) begin
      p_id[p_wr]  <= bus.rsp_id;
      p_hit[p_wr] <= bus.rsp_hit;
    end
  end

  // Pointer and occupancy bookkeeping for the three FIFOs plus the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_wr <= '0; u_rd <= '0; u_cnt <= '0;
      s_wr <= '0; s_rd <= '0; s_cnt <= '0;
      p_wr <= '0; p_rd <= '0; p_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= acc & (bus.rsp_src == 2'd3);

      if (u_push) u_wr <= u_wr + 1'b1;
      if (u_pop)  u_rd <= u_rd + 1'b1;
      if (u_push && !u_pop)      u_cnt <= u_cnt + 1'b1;
      else if (!u_push && u_pop) u_cnt <= u_cnt - 1'b1;

      if (s_push) s_wr <= s_wr + 1'b1;
      if (s_pop)  s_rd <= s_rd + 1'b1;
      if (s_push && !s_pop)      s_cnt <= s_cnt + 1'b1;
      else if (!s_push && s_pop) s_cnt <= s_cnt - 1'b1;

      if (bus.prefetch_flush) begin
        p_cnt <= '0;
        p_rd  <= p_wr;
      end else begin
        if (p_push) p_wr <= p_wr + 1'b1;
        if (p_pop)  p_rd <= p_rd + 1'b1;
        if (p_push && !p_pop)      p_cnt <= p_cnt + 1'b1;
        else if (!p_push && p_pop) p_cnt <= p_cnt - 1'b1;
      end
    end
  end

  assign bus.rsp_rdy         = rdy;
  assign bus.illegal_src_err = err_q;

  assign bus.upstream_txrsp_vld  = u_vld;
  assign bus.upstream_txrsp_id   = u_id[u_rd];
  assign bus.upstream_txrsp_hit  = u_hit[u_rd];
  assign bus.upstream_txrsp_data = u_data[u_rd];

  assign bus.downstream_txsnp_vld = s_vld;
  assign bus.downstream_txsnp_id  = s_id[s_rd];
  assign bus.downstream_txsnp_hit = s_hit[s_rd];

  assign bus.prefetch_rsp_vld = p_vld;
  assign bus.prefetch_rsp_id  = p_id[p_rd];
  assign bus.prefetch_rsp_hit = p_hit[p_rd];
endmodule

// File: tb/tb_icache_resp_dispatcher.sv
// Directed vector bench for icache_resp_dispatcher (FIFO_DEPTH=2).
module tb_icache_resp_dispatcher;
  localparam int DW = 256;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_resp_dispatcher_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  icache_resp_dispatcher #(.FIFO_DEPTH(2), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          vld;
    logic [1:0]    src;
    logic [IW-1:0] id;
    logic          ur, sr, pr, fl;
    logic          e_rdy;
    logic          e_uv;
    logic [IW-1:0] e_uid;
    logic          e_sv;
    logic [IW-1:0] e_sid;
    logic          e_pv;
    logic [IW-1:0] e_pid;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(logic vld, logic [1:0] src, logic [IW-1:0] id,
                              logic ur, logic sr, logic pr, logic fl,
                              logic e_rdy, logic e_uv, logic [IW-1:0] e_uid,
                              logic e_sv, logic [IW-1:0] e_sid,
                              logic e_pv, logic [IW-1:0] e_pid, logic e_err);
    vec_t v;
    v.vld = vld; v.src = src; v.id = id;
    v.ur = ur; v.sr = sr; v.pr = pr; v.fl = fl;
    v.e_rdy = e_rdy; v.e_uv = e_uv; v.e_uid = e_uid;
    v.e_sv = e_sv; v.e_sid = e_sid; v.e_pv = e_pv; v.e_pid = e_pid;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rsp_vld = 1'b0; bus.rsp_src = 2'd0; bus.rsp_id = '0; bus.rsp_hit = 1'b0;
    bus.rsp_data = '0; bus.prefetch_flush = 1'b0;
    bus.upstream_txrsp_rdy = 1'b1; bus.downstream_txsnp_rdy = 1'b1; bus.prefetch_rsp_rdy = 1'b1;
  endtask

  initial begin
    // Reset / idle, rdy for each src
    tbl.push_back(mk(0,0,0, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,1,0, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,2,0, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,3,0, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));
    // Routing and one-cycle latency
    tbl.push_back(mk(1,0,3, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(1,1,5, 1,1,1,0, 1,1,3, 0,0, 0,0, 0));
    tbl.push_back(mk(1,2,7, 1,1,1,0, 1,0,0, 1,5, 0,0, 0));
    tbl.push_back(mk(0,0,0, 1,1,1,0, 1,0,0, 0,0, 1,7, 0));
    tbl.push_back(mk(0,0,0, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));
    // Upstream backpressure, snoop isolation, full with simultaneous pop
    tbl.push_back(mk(1,0,1, 0,1,1,0, 1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(1,0,2, 0,1,1,0, 1,1,1, 0,0, 0,0, 0));
    tbl.push_back(mk(1,0,4, 0,1,1,0, 0,1,1, 0,0, 0,0, 0));
    tbl.push_back(mk(1,1,6, 0,1,1,0, 1,1,1, 0,0, 0,0, 0));
    tbl.push_back(mk(1,0,4, 0,1,1,0, 0,1,1, 1,6, 0,0, 0));
    tbl.push_back(mk(1,0,4, 1,1,1,0, 0,1,1, 0,0, 0,0, 0));
    tbl.push_back(mk(1,0,4, 0,1,1,0, 1,1,2, 0,0, 0,0, 0));
    tbl.push_back(mk(0,0,0, 1,1,1,0, 0,1,2, 0,0, 0,0, 0));
    tbl.push_back(mk(0,0,0, 1,1,1,0, 1,1,4, 0,0, 0,0, 0));
    tbl.push_back(mk(0,0,0, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));
    // Prefetch flush with U/S entries parked
    tbl.push_back(mk(1,2,8,  0,0,0,0, 1,0,0,  0,0,  0,0,  0));
    tbl.push_back(mk(1,2,9,  0,0,0,0, 1,0,0,  0,0,  1,8,  0));
    tbl.push_back(mk(1,0,11, 0,0,0,0, 1,0,0,  0,0,  1,8,  0));
    tbl.push_back(mk(1,1,12, 0,0,0,0, 1,1,11, 0,0,  1,8,  0));
    tbl.push_back(mk(1,2,13, 0,0,0,1, 0,1,11, 1,12, 1,8,  0));
    tbl.push_back(mk(1,2,14, 0,0,0,0, 1,1,11, 1,12, 0,0,  0));
    tbl.push_back(mk(1,2,15, 0,0,1,1, 1,1,11, 1,12, 1,14, 0));
    tbl.push_back(mk(0,0,0,  0,0,1,0, 1,1,11, 1,12, 0,0,  0));
    tbl.push_back(mk(0,0,0,  1,1,1,0, 1,1,11, 1,12, 0,0,  0));
    tbl.push_back(mk(0,0,0,  1,1,1,0, 1,0,0,  0,0,  0,0,  0));
    // Illegal source
    tbl.push_back(mk(1,3,9, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,0,0, 1,1,1,0, 1,0,0, 0,0, 0,0, 1));
    tbl.push_back(mk(0,0,0, 1,1,1,0, 1,0,0, 0,0, 0,0, 0));

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      bus.rsp_vld  = tbl[i].vld;
      bus.rsp_src  = tbl[i].src;
      bus.rsp_id   = tbl[i].id;
      bus.rsp_hit  = tbl[i].id[0];
      bus.rsp_data = {64{tbl[i].id}};
      bus.upstream_txrsp_rdy   = tbl[i].ur;
      bus.downstream_txsnp_rdy = tbl[i].sr;
      bus.prefetch_rsp_rdy     = tbl[i].pr;
      bus.prefetch_flush       = tbl[i].fl;
      #1;
      chk($sformatf("row%0d rsp_rdy", i), DW'(bus.rsp_rdy), DW'(tbl[i].e_rdy));
      chk($sformatf("row%0d u_vld", i), DW'(bus.upstream_txrsp_vld), DW'(tbl[i].e_uv));
      chk($sformatf("row%0d s_vld", i), DW'(bus.downstream_txsnp_vld), DW'(tbl[i].e_sv));
      chk($sformatf("row%0d p_vld", i), DW'(bus.prefetch_rsp_vld), DW'(tbl[i].e_pv));
      chk($sformatf("row%0d err", i), DW'(bus.illegal_src_err), DW'(tbl[i].e_err));
      if (tbl[i].e_uv) begin
        chk($sformatf("row%0d u_id", i), DW'(bus.upstream_txrsp_id), DW'(tbl[i].e_uid));
        chk($sformatf("row%0d u_hit", i), DW'(bus.upstream_txrsp_hit), DW'(tbl[i].e_uid[0]));
        chk($sformatf("row%0d u_data", i), bus.upstream_txrsp_data, {64{tbl[i].e_uid}});
      end
      if (tbl[i].e_sv) begin
        chk($sformatf("row%0d s_id", i), DW'(bus.downstream_txsnp_id), DW'(tbl[i].e_sid));
        chk($sformatf("row%0d s_hit", i), DW'(bus.downstream_txsnp_hit), DW'(tbl[i].e_sid[0]));
      end
      if (tbl[i].e_pv) begin
        chk($sformatf("row%0d p_id", i), DW'(bus.prefetch_rsp_id), DW'(tbl[i].e_pid));
        chk($sformatf("row%0d p_hit", i), DW'(bus.prefetch_rsp_hit), DW'(tbl[i].e_pid[0]));
      end
      step();
    end

    // Full-width data pattern with hit=1 on the upstream path
    idle_inputs();
    bus.rsp_vld  = 1'b1;
    bus.rsp_src  = 2'd0;
    bus.rsp_id   = 4'd3;
    bus.rsp_hit  = 1'b1;
    bus.rsp_data = {32{8'hA5}};
    #1;
    chk("a5 accept rdy", DW'(bus.rsp_rdy), DW'(1'b1));
    step();
    idle_inputs();
    #1;
    chk("a5 u_vld", DW'(bus.upstream_txrsp_vld), DW'(1'b1));
    chk("a5 u_id", DW'(bus.upstream_txrsp_id), DW'(4'd3));
    chk("a5 u_hit", DW'(bus.upstream_txrsp_hit), DW'(1'b1));
    chk("a5 u_data", bus.upstream_txrsp_data, {32{8'hA5}});
    step();
    chk("a5 u_vld drop", DW'(bus.upstream_txrsp_vld), DW'(1'b0));

    // Reset in the middle of traffic discards queued entries
    idle_inputs();
    bus.upstream_txrsp_rdy = 1'b0;
    bus.rsp_vld = 1'b1;
    bus.rsp_src = 2'd0;
    bus.rsp_id  = 4'd1;
    step();
    bus.rsp_id  = 4'd2;
    step();
    bus.rsp_vld = 1'b0;
    #1;
    chk("mid u_full rdy", DW'(bus.rsp_rdy), DW'(1'b0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid rst u_vld", DW'(bus.upstream_txrsp_vld), DW'(1'b0));
    chk("mid rst rdy", DW'(bus.rsp_rdy), DW'(1'b1));
    step();
    chk("mid rst u_vld later", DW'(bus.upstream_txrsp_vld), DW'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
